cmpf_pipe: RTL and testbench
============================

// Module: cmpf_pipe
// PURPOSE
//  Pipelined IEEE-754 floating-point comparator with elastic valid/ready handshake.
//  Joins two float operands and emits a 1-bit predicate result LATENCY cycles later.
//  Sits directly downstream of negf in dataflow circuits, e.g. comparisons on negated values.
//  Consumes negf outs/outs_valid/outs_ready on either operand; result feeds branch/select.
// PARAMETERS
//  DATA_TYPE  32  operand width; only 32 (EXP_W=8, MAN_W=23) or 64 (EXP_W=11, MAN_W=52) legal
//  PREDICATE  0   0 oeq,1 ogt,2 oge,3 olt,4 ole,5 one,6 ord,7 ueq,8 ugt,9 uge,10 ult,11 ule,12 une,13 uno
//  LATENCY    1   pipeline depth in cycles, legal 1..4
// PORTS
//  clk           in   1          clock, rising edge
//  rst           in   1          asynchronous reset, active-high
//  lhs           in   DATA_TYPE  left operand
//  lhs_valid     in   1          lhs offered
//  lhs_ready     out  1          lhs accepted this cycle
//  rhs           in   DATA_TYPE  right operand
//  rhs_valid     in   1          rhs offered
//  rhs_ready     out  1          rhs accepted this cycle
//  result        out  1          predicate outcome
//  result_valid  out  1          result offered
//  result_ready  in   1          downstream accepts result
// BEHAVIOUR
//  - Reset (async, rst=1): all stage valid bits 0, all data regs 0; result=0, result_valid=0.
//  - Join: en = ~result_valid | result_ready; lhs_ready = rhs_valid & en; rhs_ready = lhs_valid & en.
//    Transfer in only when lhs_valid & rhs_valid & en; neither operand consumed alone.
//  - Pipeline: LATENCY stages, each {valid, bit}; on en all stages shift by one, stage0 loads
//    (lhs_valid & rhs_valid) and the compare bit. en=0 freezes every stage (global stall).
//  - Latency: accepted pair -> result_valid exactly LATENCY cycles later if never stalled.
//  - Throughput: 1 pair/cycle while result_ready=1; bubbles are not compressed.
//  - Stall: result_valid=1 & result_ready=0 holds result stable; inputs see ready=0.
//  - Same-cycle result pop and input accept allowed (en=1).
//  - Compare (combinational, stage0 input):
//    NaN: exp all ones & mantissa!=0. unordered = NaN(lhs) | NaN(rhs).
//    +0 and -0 compare equal. Infinities ordered normally (-inf < finite < +inf).
//    Magnitude order: key = sign ? ~x : x ^ MSB; lt/eq on keys, zeros forced eq.
//    Ordered predicates (0..6) false when unordered; unordered ones (7..13) true when unordered.
//    one = ordered & !eq; une = unordered | !eq; ord = !unordered; uno = unordered.
//  - Illegal DATA_TYPE/PREDICATE/LATENCY: elaboration error via generate-time check.
//  - Reset mid-operation discards all in-flight results; no partial output after rst falls.
// CONFIGURATION
//  CMPF_FTZ_EN defined: subnormal operands (exp=0, mantissa!=0) flushed to signed zero before
//    compare, so any subnormal equals 0.0 and -0.0.
//  CMPF_FTZ_EN undefined: subnormals compared exactly by bit pattern order; 0x00000001 > 0.0.
// TESTING (DATA_TYPE=32 unless stated)
//  1 PREDICATE=3, LATENCY=1: lhs=0xBF800000(-1.0), rhs=0x3F800000(1.0), both valid -> result=1,
//    result_valid=1 one cycle later; lhs_ready=rhs_ready=1 in accept cycle.
//  2 PREDICATE=0: lhs=0x80000000, rhs=0x00000000 -> result=1; PREDICATE=12 same -> result=0.
//  3 NaN 0x7FC00000 vs 1.0: PREDICATE=0..6 -> 0; PREDICATE=7..13 -> 1; PREDICATE=13 -> 1.
//  4 LATENCY=3, 5 back-to-back pairs, result_ready held 0 from cycle 4 to 7 -> result stable,
//    lhs_ready=rhs_ready=0 while stalled, no loss/duplication, order preserved.
//  5 lhs_valid=1, rhs_valid=0 for 4 cycles -> lhs_ready=0, nothing enters; rhs arrives -> fires.
//  6 rst asserted with 2 results in flight -> result_valid=0 immediately; 0x00000001 vs 0x0 with
//    PREDICATE=1: result=1 without CMPF_FTZ_EN, 0 with it.

Source files
------------

// File: rtl/cmpf_pipe_if.sv
// ============================================================================
// Module : cmpf_pipe_if
// Brief  : Join/result handshake bundle for the cmpf_pipe float comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cmpf_pipe_if #(
  parameter int DATA_TYPE = 32
);
  logic [DATA_TYPE-1:0] lhs;
  logic                 lhs_valid;
  logic                 lhs_ready;
  logic [DATA_TYPE-1:0] rhs;
  logic                 rhs_valid;
  logic                 rhs_ready;
  logic                 result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (
    output lhs, lhs_valid, rhs, rhs_valid, result_ready,
    input  lhs_ready, rhs_ready, result, result_valid
  );

  modport slave (
    input  lhs, lhs_valid, rhs, rhs_valid, result_ready,
    output lhs_ready, rhs_ready, result, result_valid
  );
endinterface

`default_nettype wire

// File: rtl/cmpf_pipe.sv
// ============================================================================
// Module : cmpf_pipe
// Brief  : Pipelined IEEE-754 compare with joined operand handshake and a
//          globally stalled LATENCY-deep result pipe. Optional macro
//          CMPF_FTZ_EN flushes subnormal operands to signed zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmpf_pipe #(
  parameter int DATA_TYPE = 32,
  parameter int PREDICATE = 0,
  parameter int LATENCY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  cmpf_pipe_if.slave bus
);

  localparam int c_exp_w = (DATA_TYPE == 64) ? 11 : 8;
  localparam int c_man_w = DATA_TYPE - 1 - c_exp_w;

  if (DATA_TYPE != 32 && DATA_TYPE != 64) begin : g_bad_data_type
    $error("cmpf_pipe: DATA_TYPE must be 32 or 64");
  end
  if (PREDICATE < 0 || PREDICATE > 13) begin : g_bad_predicate
    $error("cmpf_pipe: PREDICATE must be 0..13");
  end
  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("cmpf_pipe: LATENCY must be 1..4");
  end

  function automatic logic [DATA_TYPE-1:0] prep(input logic [DATA_TYPE-1:0] x);
`ifdef CMPF_FTZ_EN
    if (x[DATA_TYPE-2 -: c_exp_w] == '0)
      return {x[DATA_TYPE-1], {(DATA_TYPE-1){1'b0}}};
    else
      return x;
`else
    return x;
`endif
  endfunction

  // Sign-magnitude to monotonic unsigned key: negatives inverted, positives get MSB set.
  function automatic logic [DATA_TYPE-1:0] key(input logic [DATA_TYPE-1:0] x);
    return x[DATA_TYPE-1] ? ~x : {1'b1, x[DATA_TYPE-2:0]};
  endfunction

  function automatic logic is_nan(input logic [DATA_TYPE-1:0] x);
    return (&x[DATA_TYPE-2 -: c_exp_w]) & (|x[c_man_w-1:0]);
  endfunction

  logic [DATA_TYPE-1:0] w_l;
  logic [DATA_TYPE-1:0] w_r;
  logic                 w_uno;
  logic                 w_both_zero;
  logic                 w_eq;
  logic                 w_lt;
  logic                 w_gt;
  logic                 w_pred;
  logic                 w_en;
  logic                 w_fire;

  assign w_l         = prep(bus.lhs);
  assign w_r         = prep(bus.rhs);
  assign w_uno       = is_nan(w_l) | is_nan(w_r);
  assign w_both_zero = (w_l[DATA_TYPE-2:0] == '0) && (w_r[DATA_TYPE-2:0] == '0);
  assign w_eq        = w_both_zero | (key(w_l) == key(w_r));
  assign w_lt        = ~w_both_zero & (key(w_l) < key(w_r));
  assign w_gt        = ~w_eq & ~w_lt;

  always_comb begin
    w_pred = 1'b0;
    case (PREDICATE)
      0:       w_pred = ~w_uno & w_eq;
      1:       w_pred = ~w_uno & w_gt;
      2:       w_pred = ~w_uno & (w_gt | w_eq);
      3:       w_pred = ~w_uno & w_lt;
      4:       w_pred = ~w_uno & (w_lt | w_eq);
      5:       w_pred = ~w_uno & ~w_eq;
      6:       w_pred = ~w_uno;
      7:       w_pred = w_uno | w_eq;
      8:       w_pred = w_uno | w_gt;
      9:       w_pred = w_uno | w_gt | w_eq;
      10:      w_pred = w_uno | w_lt;
      11:      w_pred = w_uno | w_lt | w_eq;
      12:      w_pred = w_uno | ~w_eq;
      13:      w_pred = w_uno;
      default: w_pred = 1'b0;
    endcase
  end

  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_bit;

  // Stall is global: a held output freezes every stage, bubbles included.
  assign w_en          = ~r_vld[LATENCY-1] | bus.result_ready;
  assign w_fire        = bus.lhs_valid & bus.rhs_valid;
  assign bus.lhs_ready = bus.rhs_valid & w_en;
  assign bus.rhs_ready = bus.lhs_valid & w_en;
  assign bus.result       = r_bit[LATENCY-1];
  assign bus.result_valid = r_vld[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_bit <= '0;
    end else if (w_en) begin
      r_vld[0] <= w_fire;
      r_bit[0] <= w_pred;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_bit[i] <= r_bit[i-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cmpf_pipe.sv
// ============================================================================
// Module : tb_cmpf_pipe
// Brief  : Directed bench: all 14 predicates at LATENCY=1, plus a LATENCY=3
//          olt instance for stall, ordering and reset-flush scenarios.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmpf_pipe;

  localparam int K_EQ = 0;
  localparam int K_LT = 1;
  localparam int K_GT = 2;
  localparam int K_UN = 3;

`ifdef CMPF_FTZ_EN
  localparam int K_SUB_POS = K_EQ;
  localparam int K_SUB_NEG = K_EQ;
  localparam int K_SUB_SUB = K_EQ;
`else
  localparam int K_SUB_POS = K_GT;
  localparam int K_SUB_NEG = K_LT;
  localparam int K_SUB_SUB = K_LT;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lhs = '0;
  logic [31:0] rhs = '0;
  logic        lv  = 1'b0;
  logic        rv  = 1'b0;
  logic [13:0] res_vec;
  logic [13:0] vld_vec;
  logic [13:0] lrdy_vec;
  logic [13:0] rrdy_vec;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar p = 0; p < 14; p++) begin : g_pred
    cmpf_pipe_if #(.DATA_TYPE(32)) u_if ();
    assign u_if.lhs          = lhs;
    assign u_if.rhs          = rhs;
    assign u_if.lhs_valid    = lv;
    assign u_if.rhs_valid    = rv;
    assign u_if.result_ready = 1'b1;
    assign res_vec[p]  = u_if.result;
    assign vld_vec[p]  = u_if.result_valid;
    assign lrdy_vec[p] = u_if.lhs_ready;
    assign rrdy_vec[p] = u_if.rhs_ready;
    cmpf_pipe #(.DATA_TYPE(32), .PREDICATE(p), .LATENCY(1)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );
  end

  cmpf_pipe_if #(.DATA_TYPE(32)) l3_if ();
  cmpf_pipe #(.DATA_TYPE(32), .PREDICATE(3), .LATENCY(3)) u_l3 (
    .clk (clk),
    .rst (rst),
    .bus (l3_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of predicates 0..13 (bit index = PREDICATE) for an operand relation.
  function automatic logic [13:0] mask(input int k);
    case (k)
      K_EQ:    return 14'b00101011010101;
      K_LT:    return 14'b01110001111000;
      K_GT:    return 14'b01001101100110;
      default: return 14'b11111110000000;
    endcase
  endfunction

  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b, input int k);
    @(negedge clk);
    lhs = a; rhs = b; lv = 1'b1; rv = 1'b1;
    #1;
    check({tag, "_rdy"}, {4'h0, lrdy_vec, rrdy_vec}, {4'h0, {28{1'b1}}});
    @(negedge clk);
    lv = 1'b0; rv = 1'b0;
    #1;
    check({tag, "_vld"}, {18'h0, vld_vec}, {18'h0, 14'h3fff});
    check(tag, {18'h0, res_vec}, {18'h0, mask(k)});
  endtask

  logic [31:0] a3 [5] = '{32'hBF800000, 32'h3F800000, 32'h00000000, 32'hFF800000, 32'h7FC00000};
  logic [31:0] b3 [5] = '{32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h7F800000, 32'h3F800000};
  logic        e3 [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic q [$];
    int   sent;
    int   got;
    int   first_v;

    l3_if.lhs = '0; l3_if.rhs = '0;
    l3_if.lhs_valid = 1'b0; l3_if.rhs_valid = 1'b0; l3_if.result_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_l1", {18'h0, vld_vec, res_vec}, 32'h0);
    check("rst_l3", {30'h0, l3_if.result_valid, l3_if.result}, 32'h0);
    rst = 1'b0;

    send("olt_neg1_pos1", 32'hBF800000, 32'h3F800000, K_LT);
    send("negz_posz",     32'h80000000, 32'h00000000, K_EQ);
    send("qnan_lhs",      32'h7FC00000, 32'h3F800000, K_UN);
    send("qnan_rhs",      32'h3F800000, 32'h7FC00000, K_UN);
    send("ninf_nmax",     32'hFF800000, 32'hFF7FFFFF, K_LT);
    send("pinf_pmax",     32'h7F800000, 32'h7F7FFFFF, K_GT);
    send("pinf_pinf",     32'h7F800000, 32'h7F800000, K_EQ);
    send("neg2_neg1",     32'hC0000000, 32'hBF800000, K_LT);
    send("one_one",       32'h3F800000, 32'h3F800000, K_EQ);
    send("negnan_zero",   32'hFF800001, 32'h00000000, K_UN);
    send("sub_vs_zero",   32'h00000001, 32'h00000000, K_SUB_POS);
    send("nsub_vs_zero",  32'h80000001, 32'h00000000, K_SUB_NEG);
    send("sub1_sub2",     32'h00000001, 32'h00000002, K_SUB_SUB);

    // lhs offered alone: nothing may enter until rhs shows up
    @(negedge clk);
    lhs = 32'h3F800000; rhs = 32'h40000000; lv = 1'b1; rv = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("join_lrdy", {18'h0, lrdy_vec}, 32'h0);
      check("join_rrdy", {18'h0, rrdy_vec}, {18'h0, 14'h3fff});
      check("join_vld",  {18'h0, vld_vec},  32'h0);
      @(negedge clk);
    end
    rv = 1'b1;
    #1;
    check("join_fire_rdy", {4'h0, lrdy_vec, rrdy_vec}, {4'h0, {28{1'b1}}});
    @(negedge clk);
    lv = 1'b0; rv = 1'b0;
    #1;
    check("join_vld2", {18'h0, vld_vec}, {18'h0, 14'h3fff});
    check("join_res",  {18'h0, res_vec}, {18'h0, mask(K_LT)});

    // LATENCY=3 stream with output stalled in cycles 4..7
    sent = 0; got = 0; first_v = -1;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      l3_if.result_ready = !(c >= 4 && c <= 7);
      if (sent < 5) begin
        l3_if.lhs = a3[sent]; l3_if.rhs = b3[sent];
        l3_if.lhs_valid = 1'b1; l3_if.rhs_valid = 1'b1;
      end else begin
        l3_if.lhs_valid = 1'b0; l3_if.rhs_valid = 1'b0;
      end
      #1;
      if (first_v < 0 && l3_if.result_valid) first_v = c;
      if (l3_if.result_valid && !l3_if.result_ready) begin
        check("l3_stall_lrdy", {31'h0, l3_if.lhs_ready}, 32'h0);
        check("l3_stall_rrdy", {31'h0, l3_if.rhs_ready}, 32'h0);
        if (q.size() > 0) check("l3_stall_hold", {31'h0, l3_if.result}, {31'h0, q[0]});
      end
      if (l3_if.lhs_valid && l3_if.lhs_ready) begin
        q.push_back(e3[sent]);
        sent++;
      end
      if (l3_if.result_valid && l3_if.result_ready) begin
        if (q.size() == 0) begin
          check("l3_unexpected", 32'h1, 32'h0);
        end else begin
          check("l3_pop", {31'h0, l3_if.result}, {31'h0, q.pop_front()});
        end
        got++;
      end
    end
    check("l3_latency", first_v, 32'd3);
    check("l3_sent", sent, 32'd5);
    check("l3_got", got, 32'd5);

    // reset with results in flight must drop them immediately
    @(negedge clk);
    l3_if.result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      l3_if.lhs = a3[0]; l3_if.rhs = b3[0];
      l3_if.lhs_valid = 1'b1; l3_if.rhs_valid = 1'b1;
      @(negedge clk);
    end
    l3_if.lhs_valid = 1'b0; l3_if.rhs_valid = 1'b0;
    #1;
    check("l3_pre_rst_vld", {31'h0, l3_if.result_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("l3_rst_async", {30'h0, l3_if.result_valid, l3_if.result}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    l3_if.result_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("l3_post_rst_vld", {31'h0, l3_if.result_valid}, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
